// File: rtl/dispatcher.sv
// Thread dispatcher: walks a CTA's thread IDs in groups of L, drops inactive threads and
// pushes active TIDs into per-lane dispatch FIFOs, holding a group on a load-writeback hazard.
module dispatcher #(
    parameter int FIFO_DEPTH  = 8,
    parameter int MAX_THREADS = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [1:0]                     unrolling_factor,
    input  logic [65:0]                    input_register_bitmap,
    input  logic [MAX_THREADS-1:0]         active_mask,
    input  logic [1:0]                     cta_size,
    input  logic                           fetch_done,
    input  logic                           wb_valid,
    input  logic [MAX_THREADS-1:0]         wb_tid_bitmap,
    input  logic [7:0]                     ld_dest_reg,
    input  logic [3:0]                     dispatch_fifo_pop,
    output logic [$clog2(MAX_THREADS)-1:0] dispatch_tid_0,
    output logic [$clog2(MAX_THREADS)-1:0] dispatch_tid_1,
    output logic [$clog2(MAX_THREADS)-1:0] dispatch_tid_2,
    output logic [$clog2(MAX_THREADS)-1:0] dispatch_tid_3,
    output logic                           dispatch_valid_0,
    output logic                           dispatch_valid_1,
    output logic                           dispatch_valid_2,
    output logic                           dispatch_valid_3,
    output logic                           dispatch_empty_0,
    output logic                           dispatch_empty_1,
    output logic                           dispatch_empty_2,
    output logic                           dispatch_empty_3,
    output logic                           dispatcher_busy,
    output logic                           dispatcher_done
);
    localparam int TW = $clog2(MAX_THREADS);
    localparam int PW = TW + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [PW-1:0]          ptr_reg, ptr_next;
    logic [2:0]             lanes_reg;
    logic [PW-1:0]          n_reg;
    logic [MAX_THREADS-1:0] mask_reg;
    logic [65:0]            bitmap_reg;

    logic [3:0]             grp_active, grp_blocked, grp_hit, push, fifo_full, fifo_empty;
    logic [TW-1:0]          lane_tid [4];
    logic                   start, reg_hit, stall, advance;

    assign start   = fetch_done && (state_reg == IDLE || state_reg == DONE);
    assign reg_hit = wb_valid && (ld_dest_reg < 8'd66) && bitmap_reg[ld_dest_reg[6:0]];
    assign stall   = (|grp_blocked) || (reg_hit && (|grp_hit));
    assign advance = (state_reg == SCAN) && !stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            ptr_reg    <= '0;
            lanes_reg  <= 3'd1;
            n_reg      <= PW'(256);
            mask_reg   <= '0;
            bitmap_reg <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            if (start) begin
                lanes_reg  <= (unrolling_factor == 2'd0) ? 3'd1 :
                              (unrolling_factor == 2'd1) ? 3'd2 : 3'd4;
                n_reg      <= (cta_size == 2'd0) ? PW'(256) :
                              (cta_size == 2'd1) ? PW'(512) : PW'(1024);
                mask_reg   <= active_mask;
                bitmap_reg <= input_register_bitmap;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (fetch_done) begin
                    state_next = SCAN;
                    ptr_next   = '0;
                end
            end
            SCAN: begin
                if (advance) begin
                    ptr_next = ptr_reg + PW'(lanes_reg);
                    if (ptr_reg + PW'(lanes_reg) >= n_reg)
                        state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (&fifo_empty)
                    state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign dispatcher_busy = (state_reg == SCAN) || (state_reg == DRAIN);
    assign dispatcher_done = (state_reg == DONE);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [PW-1:0] grp_tid;
            logic [TW-1:0] mem [FIFO_DEPTH];
            logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
            logic [CW-1:0] count_reg;
            logic          do_pop;

            // Groups start on a multiple of L, so slot gi always maps to lane gi.
            assign grp_tid         = ptr_reg + PW'(gi);
            assign grp_active[gi]  = (3'(gi) < lanes_reg) && (grp_tid < n_reg) &&
                                     mask_reg[grp_tid[TW-1:0]];
            assign grp_blocked[gi] = grp_active[gi] && fifo_full[gi];
            assign grp_hit[gi]     = grp_active[gi] && wb_tid_bitmap[grp_tid[TW-1:0]];
            assign push[gi]        = advance && grp_active[gi];

            assign fifo_full[gi]  = (count_reg == CW'(FIFO_DEPTH));
            assign fifo_empty[gi] = (count_reg == '0);
            assign do_pop         = dispatch_fifo_pop[gi] && !fifo_empty[gi];
            assign lane_tid[gi]   = fifo_empty[gi] ? '0 : mem[rd_ptr_reg];

            always_ff @(posedge clk) begin
                if (push[gi])
                    mem[wr_ptr_reg] <= grp_tid[TW-1:0];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push[gi])
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (do_pop)
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    count_reg <= count_reg + CW'(push[gi]) - CW'(do_pop);
                end
            end
        end
    endgenerate

    assign dispatch_tid_0   = lane_tid[0];
    assign dispatch_tid_1   = lane_tid[1];
    assign dispatch_tid_2   = lane_tid[2];
    assign dispatch_tid_3   = lane_tid[3];
    assign dispatch_empty_0 = fifo_empty[0];
    assign dispatch_empty_1 = fifo_empty[1];
    assign dispatch_empty_2 = fifo_empty[2];
    assign dispatch_empty_3 = fifo_empty[3];
    assign dispatch_valid_0 = !fifo_empty[0];
    assign dispatch_valid_1 = !fifo_empty[1];
    assign dispatch_valid_2 = !fifo_empty[2];
    assign dispatch_valid_3 = !fifo_empty[3];

endmodule

// File: tb/tb_dispatcher.sv
// Directed bench for the thread dispatcher: table of dispatch scenarios plus
// hand-written hazard, idle-mask and mid-scan reset sequences.
module tb_dispatcher;
    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       unrolling_factor;
    logic [65:0]      input_register_bitmap;
    logic [1023:0]    active_mask;
    logic [1:0]       cta_size;
    logic             fetch_done;
    logic             wb_valid;
    logic [1023:0]    wb_tid_bitmap;
    logic [7:0]       ld_dest_reg;
    logic [3:0]       pop;
    logic [3:0][9:0]  tid;
    logic [3:0]       valid, empty;
    logic             busy, done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dispatcher #(.FIFO_DEPTH(8), .MAX_THREADS(1024)) dut (
        .clk(clk), .rst(rst),
        .unrolling_factor(unrolling_factor),
        .input_register_bitmap(input_register_bitmap),
        .active_mask(active_mask), .cta_size(cta_size),
        .fetch_done(fetch_done), .wb_valid(wb_valid),
        .wb_tid_bitmap(wb_tid_bitmap), .ld_dest_reg(ld_dest_reg),
        .dispatch_fifo_pop(pop),
        .dispatch_tid_0(tid[0]), .dispatch_tid_1(tid[1]),
        .dispatch_tid_2(tid[2]), .dispatch_tid_3(tid[3]),
        .dispatch_valid_0(valid[0]), .dispatch_valid_1(valid[1]),
        .dispatch_valid_2(valid[2]), .dispatch_valid_3(valid[3]),
        .dispatch_empty_0(empty[0]), .dispatch_empty_1(empty[1]),
        .dispatch_empty_2(empty[2]), .dispatch_empty_3(empty[3]),
        .dispatcher_busy(busy), .dispatcher_done(done)
    );

    typedef struct {
        string           name;
        logic [1:0]      uf;
        logic [1:0]      cs;
        int              lo;
        int              hi;
        int              hold;
        logic [3:0][10:0] cnt;
        logic [3:0][10:0] first;
        int              stp;
    } vec_t;

    vec_t vecs [6];

    function automatic vec_t mk(string nm, logic [1:0] uf, logic [1:0] cs, int lo, int hi, int hold,
                                int c0, int c1, int c2, int c3,
                                int f0, int f1, int f2, int f3, int stp);
        vec_t v;
        v.name = nm; v.uf = uf; v.cs = cs; v.lo = lo; v.hi = hi; v.hold = hold;
        v.cnt   = {11'(c3), 11'(c2), 11'(c1), 11'(c0)};
        v.first = {11'(f3), 11'(f2), 11'(f1), 11'(f0)};
        v.stp = stp;
        return v;
    endfunction

    function automatic logic [1023:0] rng(int lo, int hi);
        logic [1023:0] r = '0;
        for (int i = lo; i <= hi; i++)
            if (i < 1024) r[i] = 1'b1;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic start(input logic [1:0] uf, input logic [1:0] cs, input logic [1023:0] m);
        unrolling_factor = uf;
        cta_size         = cs;
        active_mask      = m;
        fetch_done       = 1'b1;
        step();
        fetch_done       = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int c = 0;
        while (!done && c < budget) begin
            step();
            c++;
        end
        chk(nm, {31'd0, done}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int got [4];
        int ord_err = 0;
        int cyc = 0;
        logic [3:0] exp_v;
        for (int k = 0; k < 4; k++) got[k] = 0;
        pop = 4'h0;
        start(v.uf, v.cs, rng(v.lo, v.hi));
        if (v.hold > 0) begin
            for (int i = 0; i < v.hold; i++) step();
            for (int k = 0; k < 4; k++) exp_v[k] = (v.cnt[k] != 0);
            chk({v.name, "_hold_busy"}, {31'd0, busy}, 32'd1);
            chk({v.name, "_hold_valid"}, {28'd0, valid}, {28'd0, exp_v});
        end
        pop = 4'hF;
        while (!done && cyc < 3000) begin
            for (int k = 0; k < 4; k++) begin
                if (valid[k]) begin
                    if (32'(tid[k]) != 32'(v.first[k]) + 32'(got[k] * v.stp)) ord_err++;
                    got[k]++;
                end
            end
            step();
            cyc++;
        end
        pop = 4'h0;
        chk({v.name, "_done"}, {31'd0, done}, 32'd1);
        chk({v.name, "_busy"}, {31'd0, busy}, 32'd0);
        chk({v.name, "_order"}, ord_err, 0);
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s_cnt%0d", v.name, k), got[k], 32'(v.cnt[k]));
        $display("[TB] vector %s: lane counts %0d %0d %0d %0d", v.name, got[0], got[1], got[2], got[3]);
    endtask

    initial begin
        int bc;
        rst = 1'b1; unrolling_factor = 2'd0; input_register_bitmap = '0; active_mask = '0;
        cta_size = 2'd0; fetch_done = 1'b0; wb_valid = 1'b0; wb_tid_bitmap = '0;
        ld_dest_reg = 8'd0; pop = 4'h0;

        vecs[0] = mk("l4_n256",  2'd2, 2'd0, 0,    31,   0,   8,  8,  0 + 8, 8, 0,    1,   2,   3,   4);
        vecs[1] = mk("l1_hold",  2'd0, 2'd0, 0,    3,    270, 4,  0,  0, 0,     0,    0,   0,   0,   1);
        vecs[2] = mk("l2_full",  2'd1, 2'd0, 0,    39,   30,  20, 20, 0, 0,     0,    1,   0,   0,   2);
        vecs[3] = mk("l2_n512",  2'd1, 2'd1, 100,  139,  0,   20, 20, 0, 0,     100,  101, 0,   0,   2);
        vecs[4] = mk("l4_tail",  2'd3, 2'd0, 250,  310,  0,   1,  1,  2, 2,     252,  253, 250, 251, 4);
        vecs[5] = mk("l1_n1024", 2'd0, 2'd2, 1000, 1023, 0,   24, 0,  0, 0,     1000, 0,   0,   0,   1);

        step(); step();
        chk("rst_empty", {28'd0, empty}, 32'hF);
        chk("rst_valid", {28'd0, valid}, 32'h0);
        chk("rst_tid0", {22'd0, tid[0]}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Writeback hazard on group 0..3: dest 5 is read by the block, dest 6 is not.
        input_register_bitmap = '0;
        input_register_bitmap[5] = 1'b1;
        for (int r = 0; r < 2; r++) begin
            start(2'd2, 2'd0, rng(0, 3));
            wb_valid = 1'b1;
            ld_dest_reg = (r == 0) ? 8'd5 : 8'd6;
            wb_tid_bitmap = '0;
            wb_tid_bitmap[2] = 1'b1;
            step();
            wb_valid = 1'b0;
            chk(r == 0 ? "coll_stall_empty" : "nocoll_valid", {28'd0, valid}, r == 0 ? 32'h0 : 32'hF);
            step();
            chk(r == 0 ? "coll_resume_valid" : "nocoll_tid2", r == 0 ? {28'd0, valid} : {22'd0, tid[2]},
                r == 0 ? 32'hF : 32'd2);
            pop = 4'hF;
            wait_done(r == 0 ? "coll_done" : "nocoll_done", 400);
            pop = 4'h0;
            $display("[TB] hazard dest %0d checked", ld_dest_reg);
        end
        input_register_bitmap = '0;

        // Empty mask: 64 SCAN cycles at L=4 plus one DRAIN cycle.
        start(2'd2, 2'd0, '0);
        bc = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            if (busy) bc++;
            if (!empty[0] || !empty[1] || !empty[2] || !empty[3]) bc += 1000;
            step();
        end
        chk("zero_busy_cycles", bc, 65);
        chk("zero_done", {31'd0, done}, 32'd1);
        chk("zero_empty", {28'd0, empty}, 32'hF);
        $display("[TB] zero-mask run: busy cycles %0d", bc);

        // fetch_done while busy is ignored, then reset aborts mid-SCAN.
        start(2'd0, 2'd2, '1);
        for (int i = 0; i < 5; i++) step();
        fetch_done = 1'b1;
        step();
        fetch_done = 1'b0;
        pop = 4'h1;
        bc = 0;
        for (int i = 0; i < 10; i++) begin
            if (32'(tid[0]) != i) bc++;
            step();
        end
        chk("ignore_fetch_order", bc, 0);
        chk("ignore_fetch_busy", {31'd0, busy}, 32'd1);
        pop = 4'h0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_empty", {28'd0, empty}, 32'hF);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_tid0", {22'd0, tid[0]}, 32'd0);
        step();
        chk("midrst_idle_empty", {28'd0, empty}, 32'hF);
        $display("[TB] mid-scan reset checked");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
